// File: rtl/d3s_adc_acq_buffer.sv
// ADC acquisition buffer: on a host START it captures g_size valid samples into
// an internal RAM and serves them back over a pipelined Wishbone slave.
module d3s_adc_acq_buffer #(
    parameter int g_size       = 1024,
    parameter int g_data_width = 16
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic [g_data_width-1:0] adc_data_i,
    input  logic                    adc_valid_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [1:0]              wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    input  logic [3:0]              wb_sel_i,
    output logic [31:0]             wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_stall_o,
    output logic                    acq_busy_o,
    output logic                    acq_ready_o
);
    localparam int AW = $clog2(g_size);
    localparam logic [AW-1:0] LAST_IDX = AW'(g_size - 1);
    localparam logic [1:0] ADR_CR   = 2'd0;
    localparam logic [1:0] ADR_ADDR = 2'd1;
    localparam logic [1:0] ADR_DATA = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_r;
    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           addr_r;
    logic [g_data_width-1:0] mem_r [g_size];
    logic [g_data_width-1:0] ram_q_r;
    logic                    rd_pend_r;
    logic                    req_s;
    logic                    data_rd_s;
    logic                    accept_s;
    logic                    start_s;
    logic                    store_s;
    logic [31:0]             rd_mux_s;
    logic                    unused_s;

    assign unused_s = ^{wb_sel_i, wb_dat_i};

    // Request decode; a DATA read is held off one cycle while the RAM read completes.
    always_comb begin
        req_s      = wb_cyc_i & wb_stb_i;
        data_rd_s  = req_s & ~wb_we_i & (wb_adr_i == ADR_DATA);
        wb_stall_o = data_rd_s & ~rd_pend_r;
        accept_s   = req_s & ~wb_stall_o;
        start_s    = accept_s & wb_we_i & (wb_adr_i == ADR_CR) & wb_dat_i[0];
        store_s    = (state_r == ACQ) & adc_valid_i & ~start_s;
    end

    // Read data multiplexer, zero-extended to the bus width.
    always_comb begin
        rd_mux_s = 32'd0;
        case (wb_adr_i)
            ADR_CR:   rd_mux_s[2:0]              = {acq_busy_o, acq_ready_o, 1'b0};
            ADR_ADDR: rd_mux_s[AW-1:0]           = addr_r;
            ADR_DATA: rd_mux_s[g_data_width-1:0] = ram_q_r;
            default:  rd_mux_s                   = 32'd0;
        endcase
    end

    // Bus response and ADDR register.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 32'd0;
            rd_pend_r <= 1'b0;
            addr_r    <= '0;
        end else begin
            // An abandoned stalled read clears the pending flag as well.
            rd_pend_r <= wb_stall_o;
            wb_ack_o  <= accept_s;
            if (accept_s && !wb_we_i) begin
                wb_dat_o <= rd_mux_s;
            end else begin
                wb_dat_o <= 32'd0;
            end
            if (accept_s && wb_we_i && (wb_adr_i == ADR_ADDR)) begin
                addr_r <= wb_dat_i[AW-1:0];
            end else begin
                addr_r <= addr_r;
            end
        end
    end

    // Acquisition FSM; a START write always wins over a coincident sample.
    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            state_r     <= IDLE;
            wr_ptr_r    <= '0;
            acq_busy_o  <= 1'b0;
            acq_ready_o <= 1'b0;
        end else if (start_s) begin
            state_r     <= ACQ;
            wr_ptr_r    <= '0;
            acq_busy_o  <= 1'b1;
            acq_ready_o <= 1'b0;
        end else begin
            case (state_r)
                ACQ: begin
                    if (adc_valid_i) begin
                        if (wr_ptr_r == LAST_IDX) begin
                            state_r     <= DONE;
                            acq_busy_o  <= 1'b0;
                            acq_ready_o <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + AW'(1);
                        end
                    end else begin
                        wr_ptr_r <= wr_ptr_r;
                    end
                end
                IDLE, DONE: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r     <= IDLE;
                    acq_busy_o  <= 1'b0;
                    acq_ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Sample RAM: contents survive reset, read port is registered.
    always_ff @(posedge clk_sys_i) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= adc_data_i;
        end
        ram_q_r <= mem_r[addr_r];
    end

endmodule

// File: tb/tb_d3s_adc_acq_buffer.sv
// Directed bench for d3s_adc_acq_buffer with a behavioural capture model and
// a per-cycle compare of the status pins.
module tb_d3s_adc_acq_buffer;
    localparam int G_SIZE = 1024;
    localparam int DW     = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] adc_data = 16'd0;
    logic          adc_valid = 1'b0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    adr = 2'd0;
    logic [31:0]   dat_w = 32'd0;
    logic [3:0]    sel = 4'hF;
    logic [31:0]   dat_r;
    logic          ack;
    logic          stall;
    logic          busy;
    logic          ready;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    d3s_adc_acq_buffer #(.g_size(G_SIZE), .g_data_width(DW)) dut (
        .clk_sys_i  (clk),
        .rst_n_i    (rst_n),
        .adc_data_i (adc_data),
        .adc_valid_i(adc_valid),
        .wb_cyc_i   (cyc),
        .wb_stb_i   (stb),
        .wb_we_i    (we),
        .wb_adr_i   (adr),
        .wb_dat_i   (dat_w),
        .wb_sel_i   (sel),
        .wb_dat_o   (dat_r),
        .wb_ack_o   (ack),
        .wb_stall_o (stall),
        .acq_busy_o (busy),
        .acq_ready_o(ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: a capture is "count valid strobes until g_size".
    logic [DW-1:0] m_ram [G_SIZE];
    int   m_cnt = 0;
    int   m_addr = 0;
    logic m_busy = 1'b0;
    logic m_ready = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_addr  <= 0;
        end else begin
            if (cyc && stb && we && adr == 2'd1)
                m_addr <= int'(dat_w % 32'(G_SIZE));
            if (cyc && stb && we && adr == 2'd0 && dat_w[0]) begin
                m_busy  <= 1'b1;
                m_ready <= 1'b0;
                m_cnt   <= 0;
            end else if (m_busy && adc_valid) begin
                m_ram[m_cnt] <= adc_data;
                m_cnt <= m_cnt + 1;
                if (m_cnt == G_SIZE - 1) begin
                    m_busy  <= 1'b0;
                    m_ready <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Per-cycle compare of status pins and idle read data.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("busy_pin", busy, m_busy);
            chk1("ready_pin", ready, m_ready);
            if (!ack) chk("dat_idle", dat_r, 32'd0);
        end
    end

    // One bus transfer, starting and ending on a falling edge.
    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] rdata, output logic [31:0] lat,
                       output logic [31:0] nst);
        logic acc;
        logic got;
        acc = 1'b0; got = 1'b0; lat = 32'd0; nst = 32'd0; rdata = 32'd0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (!acc) begin
                if (stall) nst = nst + 32'd1;
                else acc = 1'b1;
            end
            @(posedge clk);
            lat = lat + 32'd1;
            @(negedge clk);
            if (acc) stb = 1'b0;
            if (ack) begin
                got = 1'b1;
                rdata = dat_r;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk1("bus_ack_timeout", got, 1'b1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] rdata, lat, nst;
        bus(1'b1, a, d, rdata, lat, nst);
        chk("wr_latency", lat, 32'd1);
    endtask

    task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rdata, lat, nst;
        bus(1'b0, a, 32'd0, rdata, lat, nst);
        chk(nm, rdata, exp);
        chk({nm, "_lat"}, lat, (a == 2'd2) ? 32'd2 : 32'd1);
        chk({nm, "_stall"}, nst, (a == 2'd2) ? 32'd1 : 32'd0);
    endtask

    task automatic samples(input int n, input int gap, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            adc_valid = 1'b1;
            adc_data  = base + DW'(i);
            @(negedge clk);
            adc_valid = 1'b0;
            adc_data  = 16'hFFFF;
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // 1: reset state
        chk1("t1_busy", busy, 1'b0);
        chk1("t1_ready", ready, 1'b0);
        rd("t1_cr", 2'd0, 32'h0);
        rd("t1_addr", 2'd1, 32'h0);
        rd("t1_word3", 2'd3, 32'h0);

        // 2: ramp capture, READY exactly one cycle after the last sample
        wr(2'd0, 32'h1);
        samples(1023, 0, 16'h0000);
        chk1("t2_ready_before", ready, 1'b0);
        samples(1, 0, 16'h03FF);
        chk1("t2_ready_after", ready, 1'b1);
        rd("t2_cr", 2'd0, 32'h2);
        for (int i = 0; i < 128; i++) begin
            wr(2'd1, 32'(i));
            rd("t2_data", 2'd2, 32'(i));
        end
        wr(2'd2, 32'hFFFF);
        wr(2'd1, 32'd3);
        rd("t2_data_wr_ignored", 2'd2, 32'h3);
        wr(2'd3, 32'h1234);
        rd("t2_word3", 2'd3, 32'h0);

        // 3: sparse strobes, gaps not stored
        wr(2'd0, 32'h1);
        samples(10, 2, 16'hA5A5);
        rd("t3_cr_busy", 2'd0, 32'h4);
        samples(1013, 2, 16'hA5AF);
        chk1("t3_ready_1023", ready, 1'b0);
        samples(1, 2, 16'hA9A4);
        chk1("t3_ready_1024", ready, 1'b1);
        wr(2'd1, 32'd0);
        rd("t3_data0", 2'd2, 32'hA5A5);
        wr(2'd1, 32'd500);
        rd("t3_data500", 2'd2, 32'hA799);
        wr(2'd1, 32'd1023);
        rd("t3_data1023", 2'd2, 32'hA9A4);

        // 4: restart mid-capture
        wr(2'd0, 32'h1);
        samples(500, 0, 16'h1000);
        wr(2'd0, 32'h1);
        samples(1023, 0, 16'h2000);
        chk1("t4_ready_1023", ready, 1'b0);
        chk1("t4_busy_1023", busy, 1'b1);
        samples(1, 0, 16'h23FF);
        chk1("t4_ready_1024", ready, 1'b1);
        wr(2'd1, 32'd0);
        rd("t4_data0", 2'd2, 32'h2000);
        wr(2'd1, 32'd600);
        rd("t4_data600", 2'd2, 32'h2258);

        // 4b: START coincident with the final sample
        wr(2'd0, 32'h1);
        samples(1023, 0, 16'h3000);
        adc_valid = 1'b1;
        adc_data  = 16'h33FF;
        wr(2'd0, 32'h1);
        adc_valid = 1'b0;
        chk1("t4b_ready", ready, 1'b0);
        chk1("t4b_busy", busy, 1'b1);
        samples(1024, 0, 16'h3000);
        chk1("t4b_ready_done", ready, 1'b1);

        // 5: ADDR wrap and DATA read timing
        wr(2'd1, 32'h405);
        rd("t5_addr_wrap", 2'd1, 32'h5);
        rd("t5_data5", 2'd2, 32'h3005);
        @(negedge clk);
        chk1("t5_ack_single", ack, 1'b0);
        rd("t5_data_model", 2'd2, {16'd0, m_ram[m_addr]});

        // 6: reset mid-capture, then full capture
        wr(2'd0, 32'h1);
        samples(200, 0, 16'h4000);
        rst_n     = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 16'h40C8;
        @(negedge clk);
        rst_n     = 1'b1;
        adc_valid = 1'b0;
        chk1("t6_busy_rst", busy, 1'b0);
        chk1("t6_ready_rst", ready, 1'b0);
        rd("t6_addr_rst", 2'd1, 32'h0);
        wr(2'd1, 32'd10);
        rd("t6_partial", 2'd2, 32'h400A);
        wr(2'd0, 32'h1);
        samples(1024, 0, 16'h5000);
        chk1("t6_ready", ready, 1'b1);
        for (int i = 0; i < G_SIZE; i++) begin
            wr(2'd1, 32'(i));
            rd("t6_data", 2'd2, {16'd0, m_ram[m_addr]});
        end
        wr(2'd1, 32'd777);
        rd("t6_data777", 2'd2, 32'h5309);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/d3s_adc_acq_buffer.md
Name: d3s_adc_acq_buffer

Overview:
Wishbone-slave acquisition buffer that sits between the ADC sample stream and the host bus. The host triggers a capture through a control register. On trigger, the block stores g_size consecutive valid ADC samples into an internal RAM, then flags READY. The host reads the samples back by writing a sample index to ADDR and reading DATA. It is the responder side of the START / poll READY / ADDR+DATA readback sequence used by host software.

Parameters:
g_size, 1024, number of samples per acquisition; power of 2, minimum 4
g_data_width, 16, ADC sample width in bits; at most 32

Ports:
clk_sys_i  in  1  system clock; samples and bus share this clock
rst_n_i  in  1  reset, synchronous, active-low
adc_data_i  in  g_data_width  ADC sample
adc_valid_i  in  1  sample strobe, one sample per asserted cycle
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  Wishbone write enable
wb_adr_i  in  2  word address: 0=CR, 1=ADDR, 2=DATA, 3=reserved
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; ignored, full-word access only
wb_dat_o  out  32  read data
wb_ack_o  out  1  Wishbone acknowledge
wb_stall_o  out  1  stall; tied 0 outside the read-DATA wait cycle
acq_busy_o  out  1  acquisition in progress
acq_ready_o  out  1  buffer full and valid

Behaviour:
Reset (rst_n_i low at a clock edge):
- FSM goes to IDLE.
- wb_ack_o=0, wb_dat_o=0, wb_stall_o=0, acq_busy_o=0, acq_ready_o=0.
- Write pointer=0, ADDR register=0.
- RAM contents are not cleared.

Register map:
- CR, word 0:
  - bit0 START: write 1 starts a capture; self-clearing; always reads 0.
  - bit1 READY: read-only, mirrors acq_ready_o.
  - bit2 BUSY: read-only, mirrors acq_busy_o.
  - Other bits read 0.
- ADDR, word 1: R/W; only the low log2(g_size) bits are stored, so values wrap modulo g_size. Reads return the stored index, zero-extended.
- DATA, word 2: read-only; returns RAM[ADDR], zero-extended to 32 bits. Writes are acked and ignored.
- Word 3: reads 0; writes are acked and ignored.

Bus timing:
- Accesses are single transfers, one outstanding at a time.
- CR, ADDR and word 3: wb_ack_o asserts exactly 1 cycle after cyc&stb is sampled, for one cycle.
- DATA reads: wb_stall_o=1 for the first request cycle, ack follows 2 cycles after the request. This covers the synchronous RAM read.
- A DATA read issued on the cycle right after an ADDR write must return the sample at the newly written index.
- wb_dat_o is valid only while wb_ack_o is high and is 0 otherwise.

FSM: states IDLE, ACQ, DONE.
- IDLE/DONE + START write → ACQ:
  - write pointer=0, acq_ready_o=0, acq_busy_o=1.
  - The transition takes effect the cycle after the write is sampled.
- ACQ + adc_valid_i:
  - RAM[wr_ptr] := adc_data_i, then wr_ptr increments.
  - When the sample is stored at g_size-1 → DONE: acq_ready_o=1, acq_busy_o=0, on the next cycle.
- ACQ + START write → restart: pointer=0, stay in ACQ, READY stays 0.
- adc_valid_i in IDLE or DONE: ignored, RAM unchanged.
- START write on the same cycle as the final sample: START wins; restart, READY not set.
- Reading DATA during ACQ is legal and returns current RAM content, which may be stale or partial.
- Reset mid-acquisition → IDLE, READY=0; the partial RAM content is retained.

Width rules:
- wr_ptr and ADDR are log2(g_size) bits.
- wr_ptr never wraps within an acquisition: the FSM leaves ACQ at g_size-1.

Test Plan:
1. Reset, then read CR → 0x0; read ADDR → 0x0; acq_ready_o=0; acq_busy_o=0.
2. Write CR=0x1, then drive ramp samples 0x0000..0x03FF with adc_valid_i every cycle (g_size=1024).
   - acq_ready_o rises one cycle after sample 0x03FF.
   - CR reads 0x2.
   - For i in 0..127, ADDR=i then DATA → i.
3. Drive adc_valid_i every 3rd cycle with data 0xA5A5+n.
   - During capture BUSY reads 1.
   - READY sets only after 1024 valid strobes; gaps are not stored.
4. Mid-capture after 500 samples, write START again.
   - Capture restarts: READY is still 0 after 1023 further samples, and 1 after the 1024th.
   - DATA[0] equals the first sample after the restart.
5. Write ADDR=0x405 → ADDR reads 0x005. Then read DATA → returns RAM[5]; ack 2 cycles after stb, with wb_stall_o high for one cycle.
6. Assert rst_n_i low for one cycle at sample 200 → BUSY=0, READY=0. Then write START and run a full capture → READY=1 and all data correct.
